jk_target_counter: RTL

//  WIDTH-bit counter register controlled by JK-style mode inputs: hold, clear, preset, count.

---
 rtl/jk_target_counter.sv | 97 +++++++++
 1 files changed

// File: rtl/jk_target_counter.sv
// jk_target_counter: WIDTH-bit JK-mode counter (hold/clear/preset/count) that wraps at TARGET.
// Optional macro JK_TARGET_STICKY_EN makes hit sticky; otherwise hit mirrors tc.
module jk_target_counter #(
   parameter int              WIDTH      = 8,
   parameter logic [WIDTH-1:0] TARGET     = WIDTH'(9),
   parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
   parameter int              WRAP_W     = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              en,
   input  logic              j,
   input  logic              k,
   output logic [WIDTH-1:0]  q,
   output logic [WIDTH-1:0]  qbar,
   output logic              tc,
   output logic [WRAP_W-1:0] wraps,
   output logic              hit
);

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_CLR,
      OP_SET,
      OP_CNT
   } op_t;

   op_t              op;
   logic             at_tgt;
   logic             below_tgt;
   logic             wrap;
   logic             wraps_full;
   logic [WIDTH-1:0] q_nxt;

   assign at_tgt     = (q == TARGET);
   assign below_tgt  = (q < TARGET);
   assign wrap       = (op == OP_CNT) && at_tgt;
   assign wraps_full = &wraps;
   assign qbar       = ~q;

   // Decode en/j/k into a single op for this edge
   always_comb begin
      op = OP_HOLD;
      if (en) begin
         unique case ({j, k})
            2'b01:   op = OP_CLR;
            2'b10:   op = OP_SET;
            2'b11:   op = OP_CNT;
            default: op = OP_HOLD;
         endcase
      end
   end

   // Next counter value; anything at or above TARGET returns to 0 on count
   always_comb begin
      q_nxt = q;
      unique case (op)
         OP_CLR:  q_nxt = '0;
         OP_SET:  q_nxt = PRESET_VAL;
         OP_CNT:  q_nxt = below_tgt ? q + WIDTH'(1) : '0;
         default: q_nxt = q;
      endcase
   end

   // Counter, terminal-count pulse and saturating wrap tally
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         q     <= '0;
         tc    <= 1'b0;
         wraps <= '0;
      end else begin
         q  <= q_nxt;
         tc <= wrap;
         if (wrap && !wraps_full)
            wraps <= wraps + WRAP_W'(1);
      end
   end

`ifdef JK_TARGET_STICKY_EN
   logic hit_q;

   // Sticky match flag: set by a wrap, dropped only by the clear op
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         hit_q <= 1'b0;
      else if (op == OP_CLR)
         hit_q <= 1'b0;
      else if (wrap)
         hit_q <= 1'b1;
   end

   assign hit = hit_q;
`else
   assign hit = tc;
`endif

endmodule
